// File: rtl/mul32_seq_ctrl_yjy.sv
// 32x32->64 multiply sequencer driving one shared 8x8 slice multiplier.
// Define MUL32_SIGNED_EN for the two's-complement build (adds the FIX state).
module mul32_seq_ctrl_yjy #(
   parameter int MUL_LAT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wi_start,
   input  logic [31:0] wi_a_32bit,
   input  logic [31:0] wi_b_32bit,
   output logic        wo_busy,
   output logic        wo_done,
   output logic [63:0] wo_prod_64bit,
   output logic [7:0]  wo_mul_a_8bit,
   output logic [7:0]  wo_mul_b_8bit,
   input  logic [15:0] wi_compr1_16bit,
   input  logic [15:0] wi_compr0_16bit
);

`ifdef MUL32_SIGNED_EN
   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

   localparam logic [4:0] LAT5 = 5'(MUL_LAT);
   localparam logic [4:0] LAST = 5'd15 + LAT5;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [63:0] acc;
   logic [63:0] acc_nxt;
   logic [63:0] prod;
   logic [7:0]  mul_a;
   logic [7:0]  mul_b;
   logic [4:0]  cyc;
   logic [4:0]  ret_full;
   logic [3:0]  ret;
   logic [3:0]  iss_nxt;
   logic        retire;
   logic [15:0] pp;
   logic [2:0]  byte_sh;
   logic [63:0] pp_sh;

   assign wo_busy       = (state != IDLE);
   assign wo_done       = (state == DONE);
   assign wo_prod_64bit = prod;
   assign wo_mul_a_8bit = mul_a;
   assign wo_mul_b_8bit = mul_b;

   // retire index lags issue index by the slice latency
   assign ret_full = cyc - LAT5;
   assign ret      = ret_full[3:0];
   assign iss_nxt  = cyc[3:0] + 4'd1;
   assign retire   = (state == RUN) && (cyc >= LAT5);
   assign pp       = wi_compr1_16bit + wi_compr0_16bit;
   assign byte_sh  = {1'b0, ret[1:0]} + {1'b0, ret[3:2]};
   assign pp_sh    = {48'd0, pp} << {byte_sh, 3'b000};

   // next state and next accumulator value
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      unique case (state)
         IDLE: begin
            if (wi_start) begin
               state_nxt = RUN;
               acc_nxt   = 64'd0;
            end
         end
         RUN: begin
            if (retire) acc_nxt = acc + pp_sh;
            if (cyc == LAST) begin
`ifdef MUL32_SIGNED_EN
               state_nxt = FIX;
`else
               state_nxt = DONE;
`endif
            end
         end
`ifdef MUL32_SIGNED_EN
         FIX: begin
            acc_nxt = acc
                    - ((a_q[31] ? {b_q, 32'd0} : 64'd0)
                    +  (b_q[31] ? {a_q, 32'd0} : 64'd0));
            state_nxt = DONE;
         end
`endif
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // operand latch, slice operand issue, accumulate, product load
   always_ff @(posedge clk) begin
      if (!rst) begin
         a_q   <= 32'd0;
         b_q   <= 32'd0;
         acc   <= 64'd0;
         prod  <= 64'd0;
         mul_a <= 8'd0;
         mul_b <= 8'd0;
         cyc   <= 5'd0;
      end else begin
         acc <= acc_nxt;
         if (state_nxt == DONE) prod <= acc_nxt;
         unique case (state)
            IDLE: begin
               if (wi_start) begin
                  a_q   <= wi_a_32bit;
                  b_q   <= wi_b_32bit;
                  cyc   <= 5'd0;
                  mul_a <= wi_a_32bit[7:0];
                  mul_b <= wi_b_32bit[7:0];
               end
            end
            RUN: begin
               cyc <= cyc + 5'd1;
               if (cyc < 5'd15) begin
                  mul_a <= a_q[{iss_nxt[1:0], 3'b000} +: 8];
                  mul_b <= b_q[{iss_nxt[3:2], 3'b000} +: 8];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul32_seq_ctrl_yjy.sv
// Scoreboard bench for mul32_seq_ctrl_yjy with a behavioural 8x8 slice.
// Expected products follow MUL32_SIGNED_EN when defined.
module tb_mul32_seq_ctrl_yjy;

`ifdef MUL32_SIGNED_EN
   localparam bit SGN = 1'b1;
`else
   localparam bit SGN = 1'b0;
`endif
   localparam int LAT = 17 + (SGN ? 1 : 0);

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        busy;
   logic        done;
   logic [63:0] prod;
   logic [7:0]  mul_a;
   logic [7:0]  mul_b;
   logic [15:0] sp;
   logic [15:0] c1;
   logic [15:0] c0;

   typedef struct {
      logic [63:0] prod;
      int          t;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_vec = 0;
   int   n_err = 0;
   int   ncount = 0;

   mul32_seq_ctrl_yjy dut (
      .clk            (clk),
      .rst            (rst),
      .wi_start       (start),
      .wi_a_32bit     (a),
      .wi_b_32bit     (b),
      .wo_busy        (busy),
      .wo_done        (done),
      .wo_prod_64bit  (prod),
      .wo_mul_a_8bit  (mul_a),
      .wo_mul_b_8bit  (mul_b),
      .wi_compr1_16bit(c1),
      .wi_compr0_16bit(c0)
   );

   // zero-latency slice split into an arbitrary carry-save pair
   assign sp = 16'(mul_a) * 16'(mul_b);
   assign c1 = sp ^ 16'hA5C3;
   assign c0 = sp - c1;

   always #5 clk = ~clk;

   function automatic logic [63:0] pick(input logic [63:0] u,
                                        input logic [63:0] s);
      return SGN ? s : u;
   endfunction

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h need %h", nm, act, req);
      end
   endtask

   // monitor: pop and compare on every done pulse
   always @(negedge clk) begin
      ncount++;
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got prod %h need no done", prod);
         end else begin
            e = sb.pop_front();
            check("prod", prod, e.prod);
            check("latency", 64'(ncount), 64'(e.t));
         end
      end
   end

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 100) begin
         @(negedge clk); #1;
         k++;
      end
      if (k == 100) begin
         n_vec++;
         n_err++;
         $display("FAIL idle_timeout: got busy 1 need 0");
      end
   endtask

   task automatic wait_drain();
      int k = 0;
      while (sb.size() != 0 && k < 200) begin
         @(negedge clk); #1;
         k++;
      end
      if (k == 200) begin
         n_vec++;
         n_err++;
         $display("FAIL done_timeout: got %0d pending need 0", sb.size());
      end
   endtask

   task automatic go(input logic [31:0] va, input logic [31:0] vb,
                     input logic [63:0] ex, input bit push);
      wait_idle();
      a = va;
      b = vb;
      start = 1'b1;
      if (push) sb.push_back('{ex, ncount + LAT});
      @(negedge clk); #1;
      start = 1'b0;
      a = ~va;
      b = ~vb;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_prod", prod, 64'd0);
      check("rst_mul_a", 64'(mul_a), 64'd0);
      check("rst_mul_b", 64'(mul_b), 64'd0);
      rst = 1'b1;
      @(negedge clk); #1;

      go(32'hFFFFFFFF, 32'hFFFFFFFF,
         pick(64'hFFFFFFFE00000001, 64'h0000000000000001), 1'b1);
      go(32'h80000000, 32'h00000002,
         pick(64'h0000000100000000, 64'hFFFFFFFF00000000), 1'b1);
      go(32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001, 1'b1);
      go(32'hFFFFFFFF, 32'h00000001,
         pick(64'h00000000FFFFFFFF, 64'hFFFFFFFFFFFFFFFF), 1'b1);
      go(32'h00000100, 32'h00000100, 64'h0000000000010000, 1'b1);
      wait_drain();

      // second start mid-RUN must be ignored
      go(32'h00010000, 32'h00010000, 64'h0000000100000000, 1'b1);
      repeat (5) @(negedge clk);
      #1;
      a = 32'd7;
      b = 32'd9;
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      wait_drain();

      // reset during RUN aborts without a done pulse
      go(32'd3, 32'd5, 64'd0, 1'b0);
      repeat (7) @(negedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk); #1;
      rst = 1'b1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_prod", prod, 64'd0);
      repeat (3) @(negedge clk);
      #1;
      go(32'd3, 32'd5, 64'd15, 1'b1);

      // start raised during DONE, accepted in the following IDLE cycle
      begin
         int k = 0;
         while (done !== 1'b1 && k < 100) begin
            @(negedge clk); #1;
            k++;
         end
         if (k == 100) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_done: got done 0 need 1");
         end
      end
      a = 32'd0;
      b = 32'h00001234;
      start = 1'b1;
      sb.push_back('{64'd0, ncount + 1 + LAT});
      @(negedge clk); #1;
      check("gap_busy", 64'(busy), 64'd0);
      @(negedge clk); #1;
      check("restart_busy", 64'(busy), 64'd1);
      start = 1'b0;
      a = 32'hDEADBEEF;
      b = 32'hCAFEF00D;
      wait_drain();
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish need finish");
      $fatal(1, "watchdog");
   end

endmodule
